// File: rtl/ring_meter.sv
// ring_meter: counts ring-oscillator rising edges per gate window and shows the total as three digits.
// Each digit uses a code in which neighbouring values differ in one bit.
// Ports:
//   i_clk   - sole clock, rising edge
//   i_rst   - asynchronous active-high reset
//   i_ring  - ring-oscillator tap, asynchronous to i_clk
//   o_100   - hundreds digit of the last completed window
//   o_010   - tens digit of the last completed window
//   o_001   - units digit of the last completed window
//   o_valid - one-cycle pulse after the digits update
//   o_ovf   - last completed window saw more than 999 edges
module ring_meter #(
    parameter int pGATE = 20_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ring,
    output logic [4:0] o_100,
    output logic [4:0] o_010,
    output logic [4:0] o_001,
    output logic       o_valid,
    output logic       o_ovf
);
    localparam logic [4:0]  ZERO = 5'b10001;
    localparam logic [4:0]  NINE = 5'b10000;
    localparam logic [15:0] LAST = 16'(pGATE - 1);

    logic        s1, s2, s3;
    logic [2:0]  warm;
    logic [15:0] gate;
    logic [4:0]  h, t, u, h_n, t_n, u_n;
    logic        ovf, ovf_n, edge_det, close, full, inc;

    function automatic logic [4:0] step(input logic [4:0] d);
        case (d)
            5'b10001: step = 5'b00001;
            5'b00001: step = 5'b00011;
            5'b00011: step = 5'b00010;
            5'b00010: step = 5'b00110;
            5'b00110: step = 5'b00100;
            5'b00100: step = 5'b01100;
            5'b01100: step = 5'b01000;
            5'b01000: step = 5'b11000;
            5'b11000: step = 5'b10000;
            default:  step = ZERO;
        endcase
    endfunction

    // warm masks edges until flop3 holds a real sample of i_ring.
    // Without it, a high level at reset release would look like a rising edge.
    assign edge_det = s2 & ~s3 & warm[2];
    assign close    = gate == LAST;
    assign full     = h == NINE && t == NINE && u == NINE;
    assign inc      = edge_det & ~full;
    assign ovf_n    = ovf | (edge_det & full);
    assign u_n      = inc ? step(u) : u;
    assign t_n      = inc && u == NINE ? step(t) : t;
    assign h_n      = inc && u == NINE && t == NINE ? step(h) : h;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            {s3, s2, s1} <= '0;
            warm         <= '0;
            gate         <= '0;
        end else begin
            {s3, s2, s1} <= {s2, s1, i_ring};
            warm         <= {warm[1:0], 1'b1};
            gate         <= close ? '0 : gate + 16'd1;
        end
    end

    // At window close, the outputs take the running totals, including an edge seen in that same cycle.
    // The running totals restart from zero on the same edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            {h, t, u} <= {ZERO, ZERO, ZERO};
            ovf       <= 1'b0;
            o_100     <= ZERO;
            o_010     <= ZERO;
            o_001     <= ZERO;
            o_ovf     <= 1'b0;
            o_valid   <= 1'b0;
        end else begin
            o_valid <= close;
            if (close) begin
                {o_100, o_010, o_001} <= {h_n, t_n, u_n};
                o_ovf                 <= ovf_n;
                {h, t, u}             <= {ZERO, ZERO, ZERO};
                ovf                   <= 1'b0;
            end else begin
                {h, t, u} <= {h_n, t_n, u_n};
                ovf       <= ovf_n;
            end
        end
    end
endmodule

// File: tb/tb_ring_meter.sv
// tb_ring_meter: directed bench for ring_meter with 100-cycle and 5000-cycle gate windows.
module tb_ring_meter;
    localparam logic [4:0] D0 = 5'b10001, D1 = 5'b00001, D2 = 5'b00011, D4 = 5'b00110;
    localparam logic [4:0] D5 = 5'b00100, D9 = 5'b10000;

    logic       clk = 1'b0, rst = 1'b1, ring = 1'b0;
    logic [4:0] a100, a010, a001, b100, b010, b001;
    logic       av, aovf, bv, bovf;
    logic [1:0] ph = 2'd0;
    int         errs = 0, checks = 0, t = 0;

    always #5 clk = ~clk;

    ring_meter #(.pGATE(100)) ua (
        .i_clk(clk), .i_rst(rst), .i_ring(ring),
        .o_100(a100), .o_010(a010), .o_001(a001), .o_valid(av), .o_ovf(aovf)
    );

    ring_meter #(.pGATE(5000)) ub (
        .i_clk(clk), .i_rst(rst), .i_ring(ring),
        .o_100(b100), .o_010(b010), .o_001(b001), .o_valid(bv), .o_ovf(bovf)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to the next n falling edges; with sq set, drive a square wave of period 4.
    task automatic steps(input int n, input bit sq = 1'b0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            t++;
            if (sq) begin
                ph++;
                ring = ph[1];
            end
        end
    endtask

    task automatic goto(input int target);
        steps(target - t);
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            ring = 1'b1;
            steps(2);
            ring = 1'b0;
            steps(2);
        end
    endtask

    initial begin
        steps(3);
        chk("rst a digits", {1'b0, a100, a010, a001}, {1'b0, D0, D0, D0});
        chk("rst a valid", 16'(av), 16'd0);
        chk("rst a ovf", 16'(aovf), 16'd0);
        chk("rst b digits", {1'b0, b100, b010, b001}, {1'b0, D0, D0, D0});
        ring = 1'b1; steps(1); ring = 1'b0; steps(1); ring = 1'b1; steps(2);
        rst = 1'b0;
        t = 0;
        goto(10); ring = 1'b0;
        goto(99);
        chk("w1 valid early", 16'(av), 16'd0);
        goto(100);
        chk("w1 valid", 16'(av), 16'd1);
        chk("w1 digits", {1'b0, a100, a010, a001}, {1'b0, D0, D0, D0});
        chk("w1 ovf", 16'(aovf), 16'd0);
        goto(101);
        chk("w1 valid width", 16'(av), 16'd0);
        chk("w1 hold", {1'b0, a100, a010, a001}, {1'b0, D0, D0, D0});
        goto(161);
        pulses(9);
        ring = 1'b1; goto(199); ring = 1'b0; goto(200);
        chk("w2 valid", 16'(av), 16'd1);
        chk("w2 digits 010", {1'b0, a100, a010, a001}, {1'b0, D0, D1, D0});
        goto(300);
        chk("w3 valid", 16'(av), 16'd1);
        chk("w3 digits 000", {1'b0, a100, a010, a001}, {1'b0, D0, D0, D0});
        ph = 2'd0;
        steps(100, 1'b1);
        chk("w4 digits 024", {1'b0, a100, a010, a001}, {1'b0, D0, D2, D4});
        steps(50, 1'b1);
        chk("w5 mid valid", 16'(av), 16'd0);
        chk("w5 mid hold", {1'b0, a100, a010, a001}, {1'b0, D0, D2, D4});
        steps(46, 1'b1);
        goto(500);
        chk("w5 valid", 16'(av), 16'd1);
        chk("w5 digits 025", {1'b0, a100, a010, a001}, {1'b0, D0, D2, D5});
        chk("w5 ovf", 16'(aovf), 16'd0);
        goto(510);
        pulses(7);
        goto(550);
        rst = 1'b1;
        #1;
        chk("mid rst digits", {1'b0, a100, a010, a001}, {1'b0, D0, D0, D0});
        chk("mid rst valid", 16'(av), 16'd0);
        chk("mid rst ovf", 16'(aovf), 16'd0);
        steps(2); ring = 1'b1; steps(2); ring = 1'b0; steps(2);
        rst = 1'b0;
        t = 0;
        goto(99);
        chk("post rst valid early", 16'(av), 16'd0);
        goto(100);
        chk("post rst valid", 16'(av), 16'd1);
        chk("post rst digits", {1'b0, a100, a010, a001}, {1'b0, D0, D0, D0});
        pulses(9);
        goto(4999);
        chk("b w1 valid early", 16'(bv), 16'd0);
        goto(5000);
        chk("b w1 valid", 16'(bv), 16'd1);
        chk("b w1 digits 009", {1'b0, b100, b010, b001}, {1'b0, D0, D0, D9});
        chk("b w1 ovf", 16'(bovf), 16'd0);
        pulses(99);
        goto(10000);
        chk("b w2 digits 099", {1'b0, b100, b010, b001}, {1'b0, D0, D9, D9});
        pulses(199);
        goto(15000);
        chk("b w3 digits 199", {1'b0, b100, b010, b001}, {1'b0, D1, D9, D9});
        ph = 2'd0;
        steps(4996, 1'b1);
        goto(20000);
        chk("b w4 valid", 16'(bv), 16'd1);
        chk("b w4 digits 999", {1'b0, b100, b010, b001}, {1'b0, D9, D9, D9});
        chk("b w4 ovf", 16'(bovf), 16'd1);
        goto(20001);
        chk("b w4 valid width", 16'(bv), 16'd0);
        chk("b w4 ovf hold", 16'(bovf), 16'd1);
        goto(25000);
        chk("b w5 digits 000", {1'b0, b100, b010, b001}, {1'b0, D0, D0, D0});
        chk("b w5 ovf", 16'(bovf), 16'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
